// File: rtl/tilemap_port_arbiter.sv
// Tile-map RAM port arbiter: the scan-out fetcher reads with absolute priority.
// Game-logic writes are buffered in a small FIFO and committed on idle port
// cycles. Whole-map clears first drain the FIFO, then fill every tile.
module tilemap_port_arbiter #(
  parameter int TILES_X    = 80,
  parameter int TILES_Y    = 60,
  parameter int ADDR_W     = 13,
  parameter int TILE_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [TILE_W-1:0] rd_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [TILE_W-1:0] wr_data_i,
  input  logic              clear_req_i,
  input  logic [TILE_W-1:0] clear_tile_i,
  output logic              busy_o,
  output logic              clear_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [TILE_W-1:0] ram_wdata_o,
  input  logic [TILE_W-1:0] ram_rdata_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NTILES = TILES_X * TILES_Y;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTILES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [TILE_W-1:0]   clr_tile_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                rd_valid_q;

  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [TILE_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q;
  logic [PTR_W-1:0]    rptr_q;
  logic [CNT_W-1:0]    count_q;

  logic fifo_empty;
  logic fifo_full;
  logic wr_ready;
  logic push;
  logic pop;
  logic clear_grant;
  logic clr_last;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [TILE_W-1:0] ram_wdata_d;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  // Held low during reset so nothing is accepted while the block is down.
  assign wr_ready    = rst_n && !fifo_full && (state_q == S_RUN);
  // Out-of-range addresses complete the handshake but never enter the FIFO.
  assign push        = wr_valid_i && wr_ready && (wr_addr_i <= LAST_ADDR);
  assign clear_grant = !rd_req_i && (state_q == S_CLEAR);
  assign pop         = !rd_req_i && (state_q != S_CLEAR) && !fifo_empty;
  assign clr_last    = clear_grant && (clr_cnt_q == LAST_ADDR);

  // Port mux: read first, then clear fill, then buffered write, else hold address.
  always_comb begin
    ram_addr_d  = last_addr_q;
    ram_wdata_d = fifo_data_q[rptr_q];
    if (rd_req_i) begin
      ram_addr_d = rd_addr_i;
    end else if (clear_grant) begin
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = clr_tile_q;
    end else if (pop) begin
      ram_addr_d = fifo_addr_q[rptr_q];
    end
  end

  assign ram_addr_o   = ram_addr_d;
  assign ram_wdata_o  = ram_wdata_d;
  assign ram_we_o     = rst_n && (clear_grant || pop);
  assign wr_ready_o   = wr_ready;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = ram_rdata_i;
  assign busy_o       = busy_q;
  assign clear_done_o = clr_last;

  // Read-valid tracks the request with the RAM's one-cycle latency; remember the last driven address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      last_addr_q <= '0;
    end else begin
      rd_valid_q  <= rd_req_i;
      last_addr_q <= ram_addr_d;
    end
  end

  // Write FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Write FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr_i;
      fifo_data_q[wptr_q] <= wr_data_i;
    end
  end

  // Clear sequencer: RUN -> DRAIN (latch fill) -> CLEAR (fill all tiles) -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      busy_q     <= 1'b0;
      clr_cnt_q  <= '0;
      clr_tile_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (clear_req_i) begin
            state_q    <= S_DRAIN;
            busy_q     <= 1'b1;
            clr_tile_q <= clear_tile_i;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          if (clear_grant) begin
            if (clr_last) begin
              state_q   <= S_RUN;
              busy_q    <= 1'b0;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
